midi_note_decoder: RTL and testbench

MIDI_NOTE_DECODER -- requirements
Module: midi_note_decoder

---
 rtl/midi_pkg.sv | 48 ++++
 rtl/midi_note_decoder.sv | 112 +++++++++++
 tb/tb_midi_note_decoder.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/midi_pkg.sv
// Shared MIDI definitions: status nibbles, realtime threshold, decoder states
// and the byte classifier used by the note decoder.
package midi_pkg;

    localparam logic [3:0] NOTE_OFF = 4'h8;
    localparam logic [3:0] NOTE_ON  = 4'h9;
    localparam logic [3:0] SYS      = 4'hF;
    localparam logic [7:0] REALTIME = 8'hF8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_NOTE = 2'd1,
        WAIT_VEL  = 2'd2,
        SKIP      = 2'd3
    } dec_state_t;

    typedef enum logic [2:0] {
        CLS_DATA     = 3'd0,
        CLS_REALTIME = 3'd1,
        CLS_SYSTEM   = 3'd2,
        CLS_NOTE     = 3'd3,
        CLS_OTHER    = 3'd4
    } byte_class_t;

    // CLS_NOTE only for note-on/off on an accepted channel; other voice
    // messages (or foreign channels) fall into CLS_OTHER and are skipped.
    function automatic byte_class_t classify_byte(
        input logic [7:0] b,
        input logic [3:0] chan,
        input logic       omni
    );
        byte_class_t cls;
        if (!b[7]) begin
            cls = CLS_DATA;
        end else if (b >= REALTIME) begin
            cls = CLS_REALTIME;
        end else if (b[7:4] == SYS) begin
            cls = CLS_SYSTEM;
        end else if (((b[7:4] == NOTE_OFF) || (b[7:4] == NOTE_ON)) &&
                     (omni || (b[3:0] == chan))) begin
            cls = CLS_NOTE;
        end else begin
            cls = CLS_OTHER;
        end
        return cls;
    endfunction

endpackage

// File: rtl/midi_note_decoder.sv
// MIDI byte-stream decoder for note-on/note-off with running status; drives
// the note number, velocity, gate and a one-cycle event pulse.
module midi_note_decoder
    import midi_pkg::*;
#(
    parameter logic [3:0] CHANNEL = 4'd0,
    parameter logic       OMNI    = 1'b0
) (
    input  logic       inCLK,
    input  logic       inRST_N,
    input  logic       inByteValid,
    input  logic [7:0] inByte,
    output logic [6:0] outMidiFrequencyIndex,
    output logic [6:0] outVelocity,
    output logic       outGate,
    output logic       outNoteEvent
);

    dec_state_t  state_reg, state_next;
    byte_class_t byte_class;
    logic        run_on_reg, run_on_next;   // running status: 1 = note-on, 0 = note-off
    logic [6:0]  note_reg, note_next;
    logic [6:0]  index_reg, index_next;
    logic [6:0]  vel_reg, vel_next;
    logic        gate_reg, gate_next;
    logic        event_reg, event_next;

    assign byte_class = classify_byte(inByte, CHANNEL, OMNI);

    always_ff @(posedge inCLK) begin
        if (!inRST_N) begin
            state_reg  <= IDLE;
            run_on_reg <= 1'b0;
            note_reg   <= 7'd0;
            index_reg  <= 7'd0;
            vel_reg    <= 7'd0;
            gate_reg   <= 1'b0;
            event_reg  <= 1'b0;
        end else begin
            state_reg  <= state_next;
            run_on_reg <= run_on_next;
            note_reg   <= note_next;
            index_reg  <= index_next;
            vel_reg    <= vel_next;
            gate_reg   <= gate_next;
            event_reg  <= event_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        run_on_next = run_on_reg;
        note_next   = note_reg;
        index_next  = index_reg;
        vel_next    = vel_reg;
        gate_next   = gate_reg;
        event_next  = 1'b0;

        if (inByteValid) begin
            unique case (byte_class)
                CLS_REALTIME: begin
                end
                CLS_SYSTEM: begin
                    state_next  = IDLE;
                    run_on_next = 1'b0;
                    note_next   = 7'd0;
                end
                CLS_NOTE: begin
                    state_next  = WAIT_NOTE;
                    run_on_next = (inByte[7:4] == NOTE_ON);
                    note_next   = 7'd0;
                end
                CLS_OTHER: begin
                    state_next  = SKIP;
                    run_on_next = 1'b0;
                    note_next   = 7'd0;
                end
                CLS_DATA: begin
                    unique case (state_reg)
                        WAIT_NOTE: begin
                            note_next  = inByte[6:0];
                            state_next = WAIT_VEL;
                        end
                        WAIT_VEL: begin
                            state_next = WAIT_NOTE;
                            if (run_on_reg && (inByte[6:0] != 7'd0)) begin
                                index_next = note_reg;
                                vel_next   = inByte[6:0];
                                gate_next  = 1'b1;
                                event_next = 1'b1;
                            end else if (gate_reg && (note_reg == index_reg)) begin
                                // Release keeps index/velocity so the voice can decay on them.
                                gate_next  = 1'b0;
                                event_next = 1'b1;
                            end
                        end
                        default: begin
                        end
                    endcase
                end
                default: begin
                end
            endcase
        end
    end

    assign outMidiFrequencyIndex = index_reg;
    assign outVelocity           = vel_reg;
    assign outGate               = gate_reg;
    assign outNoteEvent          = event_reg;

endmodule

// File: tb/tb_midi_note_decoder.sv
// Scoreboard bench: stimulus pushes expected note events, per-DUT monitors
// pop and compare on every outNoteEvent pulse, plus steady-state output checks.
module tb_midi_note_decoder;

    typedef struct {
        int         cyc;
        logic [6:0] idx;
        logic [6:0] vel;
        logic       gate;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       bv;
    logic [7:0] b;

    logic [6:0] idx_a, vel_a, idx_b, vel_b;
    logic       gate_a, ev_a, gate_b, ev_b;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    exp_t qa[$];
    exp_t qb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    midi_note_decoder #(.CHANNEL(4'd0), .OMNI(1'b0)) dut_a (
        .inCLK                 (clk),
        .inRST_N               (rst_n),
        .inByteValid           (bv),
        .inByte                (b),
        .outMidiFrequencyIndex (idx_a),
        .outVelocity           (vel_a),
        .outGate               (gate_a),
        .outNoteEvent          (ev_a)
    );

    midi_note_decoder #(.CHANNEL(4'd0), .OMNI(1'b1)) dut_b (
        .inCLK                 (clk),
        .inRST_N               (rst_n),
        .inByteValid           (bv),
        .inByte                (b),
        .outMidiFrequencyIndex (idx_b),
        .outVelocity           (vel_b),
        .outGate               (gate_b),
        .outNoteEvent          (ev_b)
    );

    // Monitors: each event pulse must match the head of its queue, in the right cycle.
    always @(negedge clk) begin
        if (ev_a) begin
            n_checks++;
            if (qa.size() == 0) begin
                $display("FAIL event_a unexpected at cyc %0d: got idx=%0d vel=%0d gate=%0d, required no event",
                         cyc, idx_a, vel_a, gate_a);
            end else begin
                exp_t e;
                e = qa.pop_front();
                if (cyc == e.cyc && idx_a == e.idx && vel_a == e.vel && gate_a == e.gate) begin
                    n_pass++;
                    $display("event_a cyc %0d idx=%0d vel=%0d gate=%0d ok", cyc, idx_a, vel_a, gate_a);
                end else begin
                    $display("FAIL event_a: got cyc=%0d idx=%0d vel=%0d gate=%0d, required cyc=%0d idx=%0d vel=%0d gate=%0d",
                             cyc, idx_a, vel_a, gate_a, e.cyc, e.idx, e.vel, e.gate);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (ev_b) begin
            n_checks++;
            if (qb.size() == 0) begin
                $display("FAIL event_b unexpected at cyc %0d: got idx=%0d vel=%0d gate=%0d, required no event",
                         cyc, idx_b, vel_b, gate_b);
            end else begin
                exp_t e;
                e = qb.pop_front();
                if (cyc == e.cyc && idx_b == e.idx && vel_b == e.vel && gate_b == e.gate) begin
                    n_pass++;
                    $display("event_b cyc %0d idx=%0d vel=%0d gate=%0d ok", cyc, idx_b, vel_b, gate_b);
                end else begin
                    $display("FAIL event_b: got cyc=%0d idx=%0d vel=%0d gate=%0d, required cyc=%0d idx=%0d vel=%0d gate=%0d",
                             cyc, idx_b, vel_b, gate_b, e.cyc, e.idx, e.vel, e.gate);
                end
            end
        end
    end

    task automatic send(input logic [7:0] v, input logic exp_a, input logic exp_b,
                        input logic [6:0] idx, input logic [6:0] vel, input logic gate);
        exp_t e;
        @(negedge clk);
        bv = 1'b1;
        b  = v;
        e.cyc  = cyc + 1;
        e.idx  = idx;
        e.vel  = vel;
        e.gate = gate;
        if (exp_a) qa.push_back(e);
        if (exp_b) qb.push_back(e);
        @(negedge clk);
        bv = 1'b0;
    endtask

    task automatic sb(input logic [7:0] v);
        send(v, 1'b0, 1'b0, 7'd0, 7'd0, 1'b0);
    endtask

    task automatic ev2(input logic [7:0] v, input logic [6:0] idx, input logic [6:0] vel,
                       input logic gate);
        send(v, 1'b1, 1'b1, idx, vel, gate);
    endtask

    task automatic check_out(input string name, input logic sel_b,
                             input logic [6:0] idx, input logic [6:0] vel, input logic gate);
        logic [6:0] gi, gv;
        logic       gg;
        gi = sel_b ? idx_b : idx_a;
        gv = sel_b ? vel_b : vel_a;
        gg = sel_b ? gate_b : gate_a;
        n_checks++;
        if (gi == idx && gv == vel && gg == gate) begin
            n_pass++;
            $display("%s idx=%0d vel=%0d gate=%0d ok", name, gi, gv, gg);
        end else begin
            $display("FAIL %s: got idx=%0d vel=%0d gate=%0d, required idx=%0d vel=%0d gate=%0d",
                     name, gi, gv, gg, idx, vel, gate);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        bv    = 1'b0;
        b     = 8'h00;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        check_out("reset_a", 1'b0, 7'd0, 7'd0, 1'b0);
        check_out("reset_b", 1'b1, 7'd0, 7'd0, 1'b0);
        n_checks++;
        if (!ev_a && !ev_b) n_pass++;
        else $display("FAIL reset_event: got a=%0b b=%0b, required 0", ev_a, ev_b);

        // Basic note-on
        sb(8'h90); sb(8'h45); ev2(8'h64, 7'd69, 7'd100, 1'b1);
        check_out("note_on", 1'b0, 7'd69, 7'd100, 1'b1);

        // Running status; then note-off for a different note is ignored
        sb(8'h40); ev2(8'h50, 7'd64, 7'd80, 1'b1);
        sb(8'h45); sb(8'h00);
        check_out("off_other_note", 1'b0, 7'd64, 7'd80, 1'b1);

        // Realtime byte inside a message
        sb(8'h90); sb(8'h3C); sb(8'hF8); ev2(8'h7F, 7'd60, 7'd127, 1'b1);
        check_out("realtime", 1'b0, 7'd60, 7'd127, 1'b1);

        // Channel 1: ignored by channel-0 decoder, accepted in omni mode
        sb(8'h91); sb(8'h3C); send(8'h7F, 1'b0, 1'b1, 7'd60, 7'd127, 1'b1);
        sb(8'h30); send(8'h22, 1'b0, 1'b1, 7'd48, 7'd34, 1'b1);
        check_out("chan1_a", 1'b0, 7'd60, 7'd127, 1'b1);
        check_out("chan1_b", 1'b1, 7'd48, 7'd34, 1'b1);

        // Note-on vel 0 as release, then explicit note-off
        sb(8'h90); sb(8'h3C); ev2(8'h40, 7'd60, 7'd64, 1'b1);
        sb(8'h3C); ev2(8'h00, 7'd60, 7'd64, 1'b0);
        check_out("on_vel0_off", 1'b0, 7'd60, 7'd64, 1'b0);
        sb(8'h90); sb(8'h3C); ev2(8'h40, 7'd60, 7'd64, 1'b1);
        sb(8'h80); sb(8'h3C); ev2(8'h00, 7'd60, 7'd64, 1'b0);
        check_out("note_off", 1'b0, 7'd60, 7'd64, 1'b0);
        sb(8'h3C); sb(8'h00);
        check_out("off_gate_low", 1'b1, 7'd60, 7'd64, 1'b0);

        // SysEx clears running status; status in WAIT_VEL drops pending note
        sb(8'h90); sb(8'h3C); ev2(8'h40, 7'd60, 7'd64, 1'b1);
        sb(8'h90); sb(8'h3D); sb(8'hF0); sb(8'h00); sb(8'h3C); sb(8'h00);
        check_out("sysex_idle", 1'b0, 7'd60, 7'd64, 1'b1);
        sb(8'h90); sb(8'h3D); sb(8'h80); sb(8'h3C); ev2(8'h00, 7'd60, 7'd64, 1'b0);
        check_out("status_in_vel", 1'b0, 7'd60, 7'd64, 1'b0);

        // Other voice message skips data bytes
        sb(8'hB0); sb(8'h3C); sb(8'h40); sb(8'h3C); sb(8'h40);
        check_out("skip_cc", 1'b0, 7'd60, 7'd64, 1'b0);

        // Reset mid-message, with a strobed status byte during reset
        sb(8'h90); sb(8'h3C);
        @(negedge clk);
        rst_n = 1'b0;
        bv    = 1'b1;
        b     = 8'h90;
        @(negedge clk);
        rst_n = 1'b1;
        bv    = 1'b0;
        check_out("mid_reset_a", 1'b0, 7'd0, 7'd0, 1'b0);
        sb(8'h40); sb(8'h7F);
        check_out("after_reset_a", 1'b0, 7'd0, 7'd0, 1'b0);
        check_out("after_reset_b", 1'b1, 7'd0, 7'd0, 1'b0);

        repeat (5) @(negedge clk);
        n_checks++;
        if (qa.size() == 0 && qb.size() == 0) n_pass++;
        else $display("FAIL missing_events: got pending a=%0d b=%0d, required 0", qa.size(), qb.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
